// File: rtl/updown_pattern_tx.sv
// -----------------------------------------------------------------------------
// updown_pattern_tx
// Transmit side of the enable/data capture link. On a start pulse it sends a
// burst of BURST_LEN words, beginning at seed and moving by step each word
// (up when dir=0, down when dir=1, wrapping modulo 2^DATA_W). Each word is
// held with enable=1 until the receiver takes it with next=1. After every
// accepted word except the last, enable is held low for GAP_CYCLES cycles.
//
// Ports
//   clock1    in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   start     in   burst request, only looked at while idle
//   dir       in   0 = increment, 1 = decrement (latched at start)
//   seed      in   first word of the burst (loaded at start)
//   step      in   delta between words (latched at start)
//   next      in   receiver ready; transfer when enable & next at posedge
//   enable    out  data_out valid
//   data_out  out  current word
//   busy      out  high outside IDLE
//   done      out  one-cycle pulse after the last transfer
//   word_cnt  out  words accepted in the current / last burst
// -----------------------------------------------------------------------------
module updown_pattern_tx #(
    parameter int DATA_W     = 4,
    parameter int BURST_LEN  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock1,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    input  logic              next,
    output logic              enable,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        word_cnt
);

    localparam logic [7:0] LEN    = 8'(BURST_LEN);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_dir, w_dir_nxt;
    logic [DATA_W-1:0] r_step, w_step_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_en, w_en_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [7:0]        r_cnt, w_cnt_nxt;
    logic [3:0]        r_gap, w_gap_nxt;

    logic [DATA_W-1:0] w_next_word;
    logic [7:0]        w_cnt_inc;

    // Arithmetic wraps naturally at DATA_W bits.
    assign w_next_word = r_dir ? (r_data - r_step) : (r_data + r_step);
    assign w_cnt_inc   = r_cnt + 8'd1;

    always_ff @(posedge clock1) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_step  <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_data  <= w_data_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_step_nxt  = r_step;
        w_data_nxt  = r_data;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        case (r_state)
            IDLE: begin
                w_en_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_dir_nxt   = dir;
                    w_step_nxt  = step;
                    w_data_nxt  = seed;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                // enable is always high here, so next alone marks a transfer
                if (next) begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_data_nxt = w_next_word;
                    if (w_cnt_inc == LEN) begin
                        w_en_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = FIN;
                    end else if (GAP_CYCLES == 0) begin
                        w_en_nxt = 1'b1;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_gap_nxt   = GAP_LD;
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                // Counter value 1 is the last low cycle; enable comes back
                // registered so the gap is exactly GAP_CYCLES long.
                if (r_gap <= 4'd1) begin
                    w_en_nxt    = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_gap_nxt = r_gap - 4'd1;
                end
            end
            FIN: begin
                w_en_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign enable   = r_en;
    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign word_cnt = r_cnt;

endmodule

// File: tb/tb_updown_pattern_tx.sv
// Three DUT copies with different burst/gap settings. The stimulus process
// pushes expected words and expected final counts into per-instance queues;
// a negedge monitor pops and compares on every transfer and done pulse.
module tb_updown_pattern_tx;

    logic clock1 = 1'b0;
    always #2 clock1 = ~clock1;

    logic [2:0]      rst_v, start_v, dir_v, next_v;
    logic [2:0][3:0] seed_v, step_v;
    wire  [2:0]      en_v, busy_v, done_v;
    wire  [3:0]      dout0, dout1, dout2;
    wire  [7:0]      wc0, wc1, wc2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] exp_w [3][$];
    int         exp_d [3][$];

    // inst0: back-to-back, 8 words; inst1: gap 2, 4 words; inst2: single word
    updown_pattern_tx #(.DATA_W(4), .BURST_LEN(8), .GAP_CYCLES(0)) u0 (
        .clock1(clock1), .rst(rst_v[0]), .start(start_v[0]), .dir(dir_v[0]),
        .seed(seed_v[0]), .step(step_v[0]), .next(next_v[0]), .enable(en_v[0]),
        .data_out(dout0), .busy(busy_v[0]), .done(done_v[0]), .word_cnt(wc0));
    updown_pattern_tx #(.DATA_W(4), .BURST_LEN(4), .GAP_CYCLES(2)) u1 (
        .clock1(clock1), .rst(rst_v[1]), .start(start_v[1]), .dir(dir_v[1]),
        .seed(seed_v[1]), .step(step_v[1]), .next(next_v[1]), .enable(en_v[1]),
        .data_out(dout1), .busy(busy_v[1]), .done(done_v[1]), .word_cnt(wc1));
    updown_pattern_tx #(.DATA_W(4), .BURST_LEN(1), .GAP_CYCLES(3)) u2 (
        .clock1(clock1), .rst(rst_v[2]), .start(start_v[2]), .dir(dir_v[2]),
        .seed(seed_v[2]), .step(step_v[2]), .next(next_v[2]), .enable(en_v[2]),
        .data_out(dout2), .busy(busy_v[2]), .done(done_v[2]), .word_cnt(wc2));

    wire [2:0][3:0] dout_v = {dout2, dout1, dout0};
    wire [2:0][7:0] wc_v   = {wc2, wc1, wc0};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock1);
        #1;
    endtask

    task automatic start_burst(input int i, input logic [3:0] sd,
                               input logic [3:0] st, input logic d);
        seed_v[i]  = sd;
        step_v[i]  = st;
        dir_v[i]   = d;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    // Monitor: checks every transfer/done against the queues plus the
    // hold-while-stalled protocol rule.
    logic [2:0]      p_en = '0, p_nx = '0, p_rst = '0;
    logic [2:0][3:0] p_dout = '0;
    always @(negedge clock1) begin
        for (int i = 0; i < 3; i++) begin
            if (p_en[i] && !p_nx[i] && !p_rst[i]) begin
                chk($sformatf("hold_en%0d", i), int'(en_v[i]), 1);
                chk($sformatf("hold_data%0d", i), int'(dout_v[i]), int'(p_dout[i]));
            end
            if (!rst_v[i] && en_v[i] && next_v[i]) begin
                chk($sformatf("xfer_expected%0d", i), int'(exp_w[i].size() > 0), 1);
                if (exp_w[i].size() > 0)
                    chk($sformatf("word%0d", i), int'(dout_v[i]), int'(exp_w[i].pop_front()));
            end
            if (done_v[i]) begin
                chk($sformatf("done_expected%0d", i), int'(exp_d[i].size() > 0), 1);
                if (exp_d[i].size() > 0)
                    chk($sformatf("done_cnt%0d", i), int'(wc_v[i]), exp_d[i].pop_front());
            end
            p_en[i]   = en_v[i];
            p_nx[i]   = next_v[i];
            p_rst[i]  = rst_v[i];
            p_dout[i] = dout_v[i];
        end
    end

    initial begin
        rst_v = '1; start_v = '0; dir_v = '0; next_v = '0;
        seed_v = '0; step_v = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_en", int'(en_v[i]), 0);
            chk("rst_data", int'(dout_v[i]), 0);
            chk("rst_busy", int'(busy_v[i]), 0);
            chk("rst_done", int'(done_v[i]), 0);
            chk("rst_cnt", int'(wc_v[i]), 0);
        end
        rst_v = '0;
        tick();

        // T1: back-to-back increment 3..A
        next_v[0] = 1'b1;
        for (int k = 0; k < 8; k++) exp_w[0].push_back(4'(3 + k));
        exp_d[0].push_back(8);
        start_burst(0, 4'h3, 4'h1, 1'b0);
        chk("t1_en_rise", int'(en_v[0]), 1);
        chk("t1_first", int'(dout0), 3);
        chk("t1_busy", int'(busy_v[0]), 1);
        chk("t1_cnt0", int'(wc0), 0);
        for (int k = 0; k < 8; k++) tick();
        chk("t1_done", int'(done_v[0]), 1);
        chk("t1_cnt", int'(wc0), 8);
        chk("t1_fin_busy", int'(busy_v[0]), 1);
        chk("t1_fin_en", int'(en_v[0]), 0);
        tick();
        chk("t1_idle_busy", int'(busy_v[0]), 0);
        chk("t1_idle_done", int'(done_v[0]), 0);
        chk("t1_hold_cnt", int'(wc0), 8);

        // T2: decrement wrap 1,E,B,8 with gap 2
        next_v[1] = 1'b1;
        exp_w[1].push_back(4'h1); exp_w[1].push_back(4'hE);
        exp_w[1].push_back(4'hB); exp_w[1].push_back(4'h8);
        exp_d[1].push_back(4);
        start_burst(1, 4'h1, 4'h3, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        chk("t2_done", int'(done_v[1]), 1);
        chk("t2_cnt", int'(wc1), 4);
        tick();
        chk("t2_idle", int'(busy_v[1]), 0);

        // T3: backpressure then gap timing; words 6,A,E,2
        next_v[1] = 1'b0;
        exp_w[1].push_back(4'h6); exp_w[1].push_back(4'hA);
        exp_w[1].push_back(4'hE); exp_w[1].push_back(4'h2);
        exp_d[1].push_back(4);
        start_burst(1, 4'h6, 4'h4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_en", int'(en_v[1]), 1);
            chk("t3_stall_data", int'(dout1), 6);
            tick();
        end
        next_v[1] = 1'b1;
        tick();
        chk("t3_gap1_en", int'(en_v[1]), 0);
        chk("t3_gap1_cnt", int'(wc1), 1);
        tick();
        chk("t3_gap2_en", int'(en_v[1]), 0);
        chk("t3_gap2_cnt", int'(wc1), 1);
        tick();
        chk("t3_resume_en", int'(en_v[1]), 1);
        chk("t3_resume_data", int'(dout1), 10);
        chk("t3_resume_cnt", int'(wc1), 1);
        for (int k = 0; k < 7; k++) tick();
        chk("t3_done", int'(done_v[1]), 1);
        chk("t3_cnt", int'(wc1), 4);
        tick();

        // T4: reset after the third transfer, then a full decrement burst
        exp_w[0].push_back(4'h5); exp_w[0].push_back(4'h7); exp_w[0].push_back(4'h9);
        start_burst(0, 4'h5, 4'h2, 1'b0);
        tick(); tick(); tick();
        chk("t4_pre_cnt", int'(wc0), 3);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("t4_rst_en", int'(en_v[0]), 0);
        chk("t4_rst_data", int'(dout0), 0);
        chk("t4_rst_cnt", int'(wc0), 0);
        chk("t4_rst_busy", int'(busy_v[0]), 0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_done", int'(done_v[0]), 0);
            tick();
        end
        exp_w[0].push_back(4'hC); exp_w[0].push_back(4'h7);
        exp_w[0].push_back(4'h2); exp_w[0].push_back(4'hD);
        exp_w[0].push_back(4'h8); exp_w[0].push_back(4'h3);
        exp_w[0].push_back(4'hE); exp_w[0].push_back(4'h9);
        exp_d[0].push_back(8);
        start_burst(0, 4'hC, 4'h5, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        chk("t4_done", int'(done_v[0]), 1);
        tick();
        chk("t4_idle", int'(busy_v[0]), 0);

        // T5: start held through busy and FIN with changed inputs
        exp_w[1].push_back(4'h2); exp_w[1].push_back(4'h3);
        exp_w[1].push_back(4'h4); exp_w[1].push_back(4'h5);
        exp_d[1].push_back(4);
        start_burst(1, 4'h2, 4'h1, 1'b0);
        seed_v[1] = 4'h9; step_v[1] = 4'h7; dir_v[1] = 1'b1; start_v[1] = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("t5_done", int'(done_v[1]), 1);
        tick();
        start_v[1] = 1'b0;
        chk("t5_fin_start_ignored", int'(busy_v[1]), 0);
        chk("t5_fin_en", int'(en_v[1]), 0);
        tick();
        chk("t5_still_idle", int'(busy_v[1]), 0);

        // T6: single constant word, no gap
        next_v[2] = 1'b1;
        exp_w[2].push_back(4'hF);
        exp_d[2].push_back(1);
        start_burst(2, 4'hF, 4'h0, 1'b0);
        chk("t6_en", int'(en_v[2]), 1);
        tick();
        chk("t6_done", int'(done_v[2]), 1);
        chk("t6_en_low", int'(en_v[2]), 0);
        tick();
        chk("t6_idle", int'(busy_v[2]), 0);

        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("left_words", exp_w[i].size(), 0);
            chk("left_done", exp_d[i].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
